nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle add/subtract unit that processes WIDTH-bit operands one 4-bit slice per clock through a single instance of the existing `four_bit_add` carry-lookahead stage. It captures the operands, feeds nibbles LSB-first into the adder, and registers the inter-nibble carry between slices. It then assembles the full sum, carry-out and signed-overflow flag. It sits upstream of `four_bit_add` as its sequencer and consumes everything that stage produces, trading latency for area in datapaths wider than 4 bits.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 4; NIB = WIDTH/4.
- clk  in  1  sole clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- sub  in  1  0 = a+b+cin, 1 = a−b (b inverted, carry-in forced to 1, cin ignored).
- a  in  WIDTH  operand A, captured on accepted start.
- b  in  WIDTH  operand B, captured on accepted start.
- cin  in  1  carry-in for add mode.
- busy  out  1  high while nibbles are being processed (RUN).
- done  out  1  one-cycle pulse: result valid.
- sum  out  WIDTH  result; holds until the next completion.
- cout  out  1  carry out of the MSB nibble; in sub mode 1 = no borrow.
- ovf  out  1  signed two's-complement overflow.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: done=1, busy=0.
- Accepted start in IDLE or DONE:
  - Latch a into shift register A_r.
  - Latch (sub ? ~b : b) into B_r.
  - Set carry register c_r = sub ? 1 : cin.
  - Clear nibble counter cnt.
  - Record sign bits a[WIDTH−1] and b_eff[WIDTH−1].
  - Go to RUN.
- Each RUN cycle:
  - Adder inputs are A_r[3:0], B_r[3:0] and c_r.
  - The adder's 4-bit sum shifts into the top of accumulator S_r; S_r shifts right by 4.
  - c_r takes the adder carry.
  - A_r and B_r shift right by 4; cnt increments.
- On the RUN cycle where cnt == NIB−1:
  - Load the sum output register with the final S_r value.
  - Set cout to the adder carry.
  - Set ovf = (a_msb == b_eff_msb) && (sum[WIDTH−1] != a_msb).
  - Go to DONE.
- DONE lasts exactly one cycle, then goes to IDLE, unless start is high, which begins a new operation (back-to-back).
- start while in RUN is ignored; operand changes after capture have no effect.
- Arithmetic is modulo 2^WIDTH; cout is the (WIDTH+1)th bit.
- sum, cout and ovf change only at completion or reset; they are stable through the following RUN period.

## Timing
- Latency: start sampled at edge 0.
  - busy high for cycles 1..NIB.
  - done, sum, cout and ovf valid in cycle NIB+1 (WIDTH=16: done 5 cycles after the start edge).
- Throughput: one result per NIB+1 cycles with back-to-back starts.
- Reset (rst=1 at a rising edge):
  - State goes to IDLE.
  - busy, done, sum, cout and ovf go to 0.
  - Internal registers and cnt are cleared.
  - Reset mid-RUN aborts without a done pulse; reset beats a simultaneous start.
- WIDTH=4: single RUN cycle, done in cycle 2.
- The combinational path is the `four_bit_add` carry chain plus one mux level; no combinational path from inputs to outputs.

## Structure
- Shared package:
  - NIB_W = 4 slice width.
  - State enum {IDLE, RUN, DONE}.
  - Counter width = clog2(NIB) (min 1).
- Sub-module: one instance of the existing `four_bit_add`; no other hierarchy.
- Datapath:
  - Registers: A_r, B_r, S_r, c_r, cnt.
  - Control: state register and next-state logic.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0, sub=0 -> sum=0x5555, cout=0, ovf=0; done in cycle 5; busy high for cycles 1–4.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 nibbles); a=0xFFFF, b=0x0000, cin=1 -> same.
- a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1; sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- sub=1, a=0x0005, b=0x0007, cin=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0 (cin ignored).
- start pulsed in cycle 2 with different operands while busy -> ignored; first result unchanged.
- Back-to-back: start held in the DONE cycle -> new op starts, second done NIB+1 cycles later.
- rst asserted in cycle 3 -> no done; all outputs 0 next cycle; a fresh start then completes normally.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
package nibble_serial_adder_pkg;

    // Operand bits consumed per clock.
    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Slice counter width; never narrower than one bit so WIDTH=4 still has a counter.
    function automatic int unsigned cnt_width(input int unsigned nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/four_bit_add.sv
// 4-bit carry-lookahead adder stage: sum = a + b + cin, with carry out.
module four_bit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate terms with all carries expanded directly from cin.
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle add/subtract: one 4-bit slice per clock through a single four_bit_add,
// LSB nibble first, with the inter-slice carry held in a register.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NIB  = WIDTH / NIB_W;
    localparam int unsigned CNTW = cnt_width(NIB);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              c_q, c_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [WIDTH-1:0]  b_eff;
    logic [NIB_W-1:0]  add_sum;
    logic              add_cout;
    logic [WIDTH-1:0]  s_shift;
    logic              last;

    four_bit_add u_add (
        .a    (a_q[NIB_W-1:0]),
        .b    (b_q[NIB_W-1:0]),
        .cin  (c_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Slice datapath: new nibble enters the top of the accumulator as it shifts right.
    always_comb begin
        b_eff   = sub ? ~b : b;
        s_shift = (s_q >> NIB_W) | (WIDTH'(add_sum) << (WIDTH - NIB_W));
        last    = (cnt_q == CNTW'(NIB - 1));
    end

    // Next-state and register updates for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    a_d     = a;
                    b_d     = b_eff;
                    s_d     = '0;
                    c_d     = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b_eff[WIDTH-1];
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d   = a_q >> NIB_W;
                b_d   = b_q >> NIB_W;
                s_d   = s_shift;
                c_d   = add_cout;
                cnt_d = cnt_q + CNTW'(1);
                if (last) begin
                    sum_d   = s_shift;
                    cout_d  = add_cout;
                    ovf_d   = (a_msb_q == b_msb_q) && (s_shift[WIDTH-1] != a_msb_q);
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs come straight from registers; no input-to-output combinational path.
    always_comb begin
        busy = (state_q == StRun);
        done = (state_q == StDone);
        sum  = sum_q;
        cout = cout_q;
        ovf  = ovf_q;
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: table vectors plus hand sequences, results via a scoreboard queue.
module tb_nibble_serial_adder;

    localparam int unsigned W   = 16;
    localparam int unsigned NIB = W / 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // {ovf, cout, sum}
    logic [W+1:0] sb[$];

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic on a WIDTH+1 bit sum.
    function automatic logic [W+1:0] model(input logic s, input logic [W-1:0] x,
                                           input logic [W-1:0] y, input logic ci);
        logic [W-1:0] ye;
        logic [W:0]   r;
        logic         v;
        ye = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, (s ? 1'b1 : ci)};
        v  = (x[W-1] == ye[W-1]) && (r[W-1] != x[W-1]);
        return {v, r[W], r[W-1:0]};
    endfunction

    // Result checker: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected done", 32'(done), 32'd0);
            end else begin
                logic [W+1:0] e;
                e = sb.pop_front();
                check("result sum", 32'(sum), 32'(e[W-1:0]));
                check("result cout", 32'(cout), 32'(e[W]));
                check("result ovf", 32'(ovf), 32'(e[W+1]));
            end
        end
    end

    task automatic drive_start(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic ci);
        start = 1'b1;
        sub   = s;
        a     = x;
        b     = y;
        cin   = ci;
    endtask

    // Call at a negedge: drives start there, checks busy timing, returns at the done negedge.
    task automatic run_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic [W+1:0] exp, input string tag);
        drive_start(s, x, y, ci);
        sb.push_back(exp);
        for (int k = 1; k <= NIB; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            check({tag, " busy/done in RUN"}, 32'({busy, done}), 32'b10);
        end
        @(negedge clk);
        check({tag, " busy/done in DONE"}, 32'({busy, done}), 32'b01);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout/ovf", 32'({cout, ovf}), 32'd0);
        rst = 1'b0;

        // Table-driven vectors with hand-computed expectations.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            run_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin,
                   {vecs[i].ovf, vecs[i].cout, vecs[i].sum}, $sformatf("vec%0d", i));
            @(negedge clk);
            check($sformatf("vec%0d done one cycle", i), 32'({busy, done}), 32'b00);
        end

        // Start pulsed while busy with different operands must be ignored.
        @(negedge clk);
        drive_start(1'b0, 16'h1000, 16'h0234, 1'b0);
        sb.push_back({1'b0, 1'b0, 16'h1234});
        for (int k = 1; k <= NIB; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 2) drive_start(1'b1, 16'hAAAA, 16'h5555, 1'b1);
            if (k == 3) start = 1'b0;
            check("ignored start busy", 32'({busy, done}), 32'b10);
        end
        @(negedge clk);
        check("ignored start done", 32'({busy, done}), 32'b01);
        @(negedge clk);
        check("ignored start no second op", 32'({busy, done}), 32'b00);

        // Back-to-back: second start held in the DONE cycle.
        @(negedge clk);
        run_op(1'b0, 16'h0F0F, 16'h0101, 1'b1, model(1'b0, 16'h0F0F, 16'h0101, 1'b1), "b2b1");
        run_op(1'b1, 16'h1000, 16'h0001, 1'b0, model(1'b1, 16'h1000, 16'h0001, 1'b0), "b2b2");
        @(negedge clk);
        check("b2b idle after", 32'({busy, done}), 32'b00);
        check("b2b sum held", 32'(sum), 32'h0FFF);

        // Reset mid-RUN aborts without a done pulse and clears outputs.
        @(negedge clk);
        drive_start(1'b0, 16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid-run reset busy/done", 32'({busy, done}), 32'b00);
        check("mid-run reset sum", 32'(sum), 32'd0);
        check("mid-run reset cout/ovf", 32'({cout, ovf}), 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Reset wins over a simultaneous start.
        rst = 1'b1;
        drive_start(1'b0, 16'h0001, 16'h0001, 1'b0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("reset beats start", 32'({busy, done}), 32'b00);

        // Fresh operation after reset, then random operands against the model.
        run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, model(1'b0, 16'h00FF, 16'h0001, 1'b0), "fresh");
        for (int i = 0; i < 8; i++) begin
            logic         rs;
            logic         rc;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            ra = W'($urandom);
            rb = W'($urandom);
            @(negedge clk);
            run_op(rs, ra, rb, rc, model(rs, ra, rb, rc), $sformatf("rand%0d", i));
        end

        for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
